bin2bcd_dd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- An optional output mode re-codes every result digit to excess-3 (digit + 3).
- One bit is processed per clock; start/busy/done handshake.
- Sits between binary arithmetic datapaths and decimal display/output logic, replacing fixed-width combinational add-3 cells.

---
 rtl/bin2bcd_dd_seq.sv | 130 +++++++++++++
 tb/tb_bin2bcd_dd_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_dd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One binary bit is consumed per clock. The result is optionally re-coded to
// excess-3 when it is registered. `ovf` flags operands that do not fit in
// DIGITS decimal digits; in that case bcd_out holds bin_in mod 10^DIGITS.
module bin2bcd_dd_seq #(
  parameter int WIDTH   = 8,  // binary operand width, 1..32
  parameter int DIGITS  = 3,  // BCD result digits, 1..10
  parameter int EXCESS3 = 0   // 1: output digits are BCD + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;           // BCD part of the working register
  localparam int SW = BW + WIDTH;           // whole {BCD, binary} register
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   shift_q, shift_d;      // {BCD digits, remaining binary bits}
  logic [CW-1:0]   cnt_q, cnt_d;          // shifts already performed
  logic            ovf_int_q, ovf_int_d;  // sticky carry out of the top digit
  logic [BW-1:0]   bcd_out_q, bcd_out_d;
  logic            ovf_q, ovf_d;

  logic [SW-1:0]   corr;                  // register after add-3 correction
  logic [SW-1:0]   shifted;               // corrected register shifted left
  logic            carry;                 // bit leaving the top digit
  logic            last_shift;
  logic            accept;

  // A start is honoured in IDLE and in the DONE cycle (back-to-back).
  assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_shift = (cnt_q == CW'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: add 3 to each digit >= 5, then shift the whole register left.
  // A corrected digit is at most 12, so the 4-bit add never wraps, and the
  // bit leaving the top digit is exactly the decimal carry out.
  always_comb begin
    corr = shift_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_q[WIDTH + 4*i +: 4] >= 4'd5)
        corr[WIDTH + 4*i +: 4] = shift_q[WIDTH + 4*i +: 4] + 4'd3;
    end
    carry   = corr[SW-1];
    shifted = {corr[SW-2:0], 1'b0};
  end

  // Next values of the working registers and of the held result.
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    if (accept) begin
      shift_d   = {{BW{1'b0}}, bin_in};
      cnt_d     = '0;
      ovf_int_d = 1'b0;
    end else if (state_q == SHIFT) begin
      shift_d   = shifted;
      cnt_d     = CW'(cnt_q + 1'b1);
      ovf_int_d = ovf_int_q | carry;
      if (last_shift) begin
        // Excess-3 is a pure output re-code; the iteration stays plain BCD.
        for (int i = 0; i < DIGITS; i++)
          bcd_out_d[4*i +: 4] = shifted[WIDTH + 4*i +: 4]
                              + ((EXCESS3 != 0) ? 4'd3 : 4'd0);
        ovf_d = ovf_int_q | carry;
      end
    end
  end

  // Working and result registers.
  // NOTE: these are ordinary flops, not a memory array, so they all take the
  // reset; a reset mid-conversion therefore leaves no stale partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      bcd_out_q <= bcd_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_dd_seq.sv
// Bench for bin2bcd_dd_seq: four configurations share one clock and reset.
// Stimulus pushes hand-computed results into per-instance queues; a monitor
// pops and compares whenever an instance pulses done.
module tb_bin2bcd_dd_seq;

  localparam int NDUT = 4;
  // 0: W8/D3  1: W8/D3/excess-3  2: W8/D2  3: W16/D5
  localparam int WID [NDUT] = '{8, 8, 8, 16};

  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
    logic [31:0] cyc;   // cycle count at which done must be seen
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [NDUT];
  logic [31:0] bin_s   [NDUT];
  logic        busy_s  [NDUT];
  logic        done_s  [NDUT];
  logic        ovf_s   [NDUT];
  logic [19:0] bcd_s   [NDUT];
  logic [11:0] bcd0, bcd1;
  logic [7:0]  bcd2;
  logic [19:0] bcd3;

  exp_t        q [NDUT][$];
  exp_t        mon_e;
  logic [31:0] cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_dd_seq #(.WIDTH(8), .DIGITS(3), .EXCESS3(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .bin_in(bin_s[0][7:0]),
    .busy(busy_s[0]), .done(done_s[0]), .bcd_out(bcd0), .ovf(ovf_s[0]));
  bin2bcd_dd_seq #(.WIDTH(8), .DIGITS(3), .EXCESS3(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .bin_in(bin_s[1][7:0]),
    .busy(busy_s[1]), .done(done_s[1]), .bcd_out(bcd1), .ovf(ovf_s[1]));
  bin2bcd_dd_seq #(.WIDTH(8), .DIGITS(2), .EXCESS3(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .bin_in(bin_s[2][7:0]),
    .busy(busy_s[2]), .done(done_s[2]), .bcd_out(bcd2), .ovf(ovf_s[2]));
  bin2bcd_dd_seq #(.WIDTH(16), .DIGITS(5), .EXCESS3(0)) u_d3 (
    .clk(clk), .rst(rst), .start(start_s[3]), .bin_in(bin_s[3][15:0]),
    .busy(busy_s[3]), .done(done_s[3]), .bcd_out(bcd3), .ovf(ovf_s[3]));

  assign bcd_s[0] = {8'd0, bcd0};
  assign bcd_s[1] = {8'd0, bcd1};
  assign bcd_s[2] = {12'd0, bcd2};
  assign bcd_s[3] = bcd3;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a negedge: raise start for one edge and, if push is set, queue
  // the expected result. Returns at the negedge after the accepting edge.
  task automatic issue(input int d, input logic [31:0] v,
                       input logic [19:0] eb, input logic eo, input bit push);
    start_s[d] = 1'b1;
    bin_s[d]   = v;
    if (push) q[d].push_back('{bcd: eb, ovf: eo, cyc: cyc + 32'(1 + WID[d])});
    @(negedge clk);
    start_s[d] = 1'b0;
    bin_s[d]   = 32'hDEAD_BEEF;
  endtask

  // One complete conversion, returning at the idle cycle after done.
  task automatic conv(input int d, input logic [31:0] v,
                      input logic [19:0] eb, input logic eo);
    issue(d, v, eb, eo, 1'b1);
    repeat (WID[d]) @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare every done pulse against the queue; flag late results.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < NDUT; d++) begin
        if (done_s[d]) begin
          if (q[d].size() == 0) begin
            check($sformatf("spurious_done_%0d", d), 32'(done_s[d]), 32'd0);
          end else begin
            mon_e = q[d].pop_front();
            check($sformatf("bcd_%0d", d), 32'(bcd_s[d]), 32'(mon_e.bcd));
            check($sformatf("ovf_%0d", d), 32'(ovf_s[d]), 32'(mon_e.ovf));
            check($sformatf("done_cycle_%0d", d), cyc, mon_e.cyc);
            check($sformatf("busy_in_done_%0d", d), 32'(busy_s[d]), 32'd0);
          end
        end else if (q[d].size() != 0 && q[d][0].cyc < cyc) begin
          mon_e = q[d].pop_front();
          check($sformatf("done_missing_%0d", d), cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      start_s[d] = 1'b0;
      bin_s[d]   = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_bcd_%0d", d), 32'(bcd_s[d]), 32'd0);
      check($sformatf("rst_busy_%0d", d), 32'(busy_s[d]), 32'd0);
      check($sformatf("rst_done_%0d", d), 32'(done_s[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 255: busy for exactly 8 cycles, then a one-cycle done.
    issue(0, 32'd255, 20'h255, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("busy_high", 32'(busy_s[0]), 32'd1);
      @(negedge clk);
    end
    check("busy_low_at_done", 32'(busy_s[0]), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'(done_s[0]), 32'd0);

    // Back-to-back: second start held in the done cycle of the first.
    issue(0, 32'd0, 20'h000, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    issue(0, 32'd9, 20'h009, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    conv(0, 32'd128, 20'h128, 1'b0);

    // Excess-3 output coding.
    conv(1, 32'd255, 20'h588, 1'b0);
    conv(1, 32'd0,   20'h333, 1'b0);
    conv(1, 32'd47,  20'h37A, 1'b0);

    // Two digits: truncation and overflow boundary at 100.
    conv(2, 32'd199, 20'h99, 1'b1);
    conv(2, 32'd99,  20'h99, 1'b0);
    conv(2, 32'd150, 20'h50, 1'b1);
    conv(2, 32'd100, 20'h00, 1'b1);

    // Sixteen-bit operand, five digits.
    conv(3, 32'd65535, 20'h65535, 1'b0);
    conv(3, 32'd1234,  20'h01234, 1'b0);
    conv(3, 32'd40000, 20'h40000, 1'b0);

    // Start while busy is ignored, not queued.
    issue(0, 32'd100, 20'h100, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start_s[0] = 1'b1;
    bin_s[0]   = 32'd7;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    check("held_after_ignored_start", 32'(bcd_s[0]), 32'h100);
    repeat (10) @(negedge clk);

    // Reset mid-conversion: outputs clear at once, no done afterwards.
    issue(0, 32'd55, 20'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("midrst_bcd_%0d", d), 32'(bcd_s[d]), 32'd0);
      check($sformatf("midrst_ovf_%0d", d), 32'(ovf_s[d]), 32'd0);
      check($sformatf("midrst_busy_%0d", d), 32'(busy_s[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_after_abort", 32'(busy_s[0]), 32'd0);

    // Drain with a bound, then account for anything never delivered.
    for (int i = 0; i < 50; i++) begin
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
      @(negedge clk);
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("leftover_%0d", d), 32'(q[d].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
